// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the LCD frame sequencer.
// The LCD_FRAME_DIRTY_EN build macro is consumed by the files that import this package.
package lcd_pkg;

   localparam logic [7:0] LCD_LINE0_ADDR  = 8'h80;
   localparam logic [7:0] LCD_LINE1_ADDR  = 8'hC0;
   localparam logic [7:0] LCD_CHAR_SPACE  = 8'h20;
   localparam int         LCD_COLS        = 16;
   localparam int         LCD_LINES       = 2;
   localparam int         LCD_CELLS       = LCD_COLS * LCD_LINES;
   localparam int         LCD_GAP_US      = 50;
   localparam int         LCD_ACK_TIMEOUT = 16;
   localparam int         LCD_CNT_W       = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LINE_CMD,
      ST_CHAR,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_GAP,
      ST_FINISH
   } lcd_state_e;

   function automatic logic [7:0] lcd_line_addr(input logic line);
      return line ? LCD_LINE1_ADDR : LCD_LINE0_ADDR;
   endfunction

endpackage

// File: rtl/lcd_frame_buf.sv
// 2x16 character frame buffer: synchronous write, asynchronous read.
// With LCD_FRAME_DIRTY_EN defined it also keeps one dirty bit per line.
module lcd_frame_buf
   import lcd_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [7:0]           wr_data,
   input  logic [4:0]           rd_addr,
   output logic [7:0]           rd_data
`ifdef LCD_FRAME_DIRTY_EN
   ,
   input  logic                 dirty_clr,
   input  logic                 dirty_clr_line,
   output logic [LCD_LINES-1:0] dirty
`endif
);

   logic [7:0] mem [LCD_CELLS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LCD_CELLS; i++) mem[i] <= LCD_CHAR_SPACE;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

`ifdef LCD_FRAME_DIRTY_EN
   // A write landing on the same edge as the clear wins, so the line is re-sent later.
   always_ff @(posedge clk) begin
      if (rst) begin
         dirty <= '1;
      end else begin
         if (dirty_clr) dirty[dirty_clr_line] <= 1'b0;
         if (wr_en)     dirty[wr_addr[4]]     <= 1'b1;
      end
   end
`endif

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Streams the 2x16 frame buffer to the HD44780 byte driver with a settle gap per byte.
// Build macro LCD_FRAME_DIRTY_EN: send only lines written since they were last sent.
//
// state     | meaning
// IDLE      | waiting for refresh or pending refresh
// LINE_CMD  | stage DDRAM address command for current line
// CHAR      | stage buffer char at (line, col)
// ISSUE     | wait driver idle, pulse lcd_start with staged byte
// WAIT_ACK  | wait driver busy rise; time out and re-issue same byte
// WAIT_DONE | wait driver busy fall
// GAP       | settle delay, then pick next byte
// FINISH    | pulse done, drop frame_busy
module lcd_frame_sequencer
   import lcd_pkg::*;
#(
   parameter int CLK_HZ      = 12_000_000,
   parameter int GAP_CYCLES  = (CLK_HZ / 1_000_000) * LCD_GAP_US,
   parameter int ACK_TIMEOUT = LCD_ACK_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       refresh,
   output logic       frame_busy,
   output logic       done,
   output logic       lcd_start,
   output logic       lcd_rs,
   output logic [7:0] lcd_data,
   input  logic       lcd_busy
);

   localparam logic [3:0] LAST_COL = 4'(LCD_COLS - 1);

   lcd_state_e           state;
   logic                 line;
   logic [3:0]           col;
   logic                 stage_cmd;
   logic [7:0]           stage_data;
   logic [LCD_CNT_W-1:0] cnt;
   logic                 pending;
   logic [7:0]           rd_data;

`ifdef LCD_FRAME_DIRTY_EN
   logic [LCD_LINES-1:0] dirty;
   logic                 dirty_clr;

   // Clearing on the LINE_CMD cycle lets a write in that same cycle re-mark the line.
   assign dirty_clr = (state == ST_LINE_CMD);
`endif

   lcd_frame_buf u_buf (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rd_addr        ({line, col}),
      .rd_data        (rd_data)
`ifdef LCD_FRAME_DIRTY_EN
      ,
      .dirty_clr      (dirty_clr),
      .dirty_clr_line (line),
      .dirty          (dirty)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         line       <= 1'b0;
         col        <= '0;
         stage_cmd  <= 1'b0;
         stage_data <= '0;
         cnt        <= '0;
         pending    <= 1'b0;
         frame_busy <= 1'b0;
         done       <= 1'b0;
         lcd_start  <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= '0;
      end else begin
         done      <= 1'b0;
         lcd_start <= 1'b0;
         if (refresh && state != ST_IDLE) pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (refresh || pending) begin
                  pending <= 1'b0;
`ifdef LCD_FRAME_DIRTY_EN
                  if (dirty == '0) begin
                     done <= 1'b1;
                  end else begin
                     frame_busy <= 1'b1;
                     line       <= ~dirty[0];
                     col        <= '0;
                     state      <= ST_LINE_CMD;
                  end
`else
                  frame_busy <= 1'b1;
                  line       <= 1'b0;
                  col        <= '0;
                  state      <= ST_LINE_CMD;
`endif
               end
            end
            ST_LINE_CMD: begin
               stage_cmd  <= 1'b1;
               stage_data <= lcd_line_addr(line);
               state      <= ST_ISSUE;
            end
            ST_CHAR: begin
               stage_cmd  <= 1'b0;
               stage_data <= rd_data;
               state      <= ST_ISSUE;
            end
            ST_ISSUE: begin
               if (!lcd_busy) begin
                  lcd_start <= 1'b1;
                  lcd_rs    <= ~stage_cmd;
                  lcd_data  <= stage_data;
                  cnt       <= LCD_CNT_W'(ACK_TIMEOUT - 1);
                  state     <= ST_WAIT_ACK;
               end
            end
            ST_WAIT_ACK: begin
               if (lcd_busy)        state <= ST_WAIT_DONE;
               else if (cnt == '0)  state <= ST_ISSUE;
               else                 cnt   <= cnt - 1'b1;
            end
            ST_WAIT_DONE: begin
               if (!lcd_busy) begin
                  cnt   <= LCD_CNT_W'(GAP_CYCLES - 1);
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (stage_cmd) begin
                  state <= ST_CHAR;
               end else if (col != LAST_COL) begin
                  col   <= col + 4'd1;
                  state <= ST_CHAR;
               end else if (!line) begin
`ifdef LCD_FRAME_DIRTY_EN
                  if (dirty[1]) begin
                     line  <= 1'b1;
                     col   <= '0;
                     state <= ST_LINE_CMD;
                  end else begin
                     state <= ST_FINISH;
                  end
`else
                  line  <= 1'b1;
                  col   <= '0;
                  state <= ST_LINE_CMD;
`endif
               end else begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               done       <= 1'b1;
               frame_busy <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench for lcd_frame_sequencer with a behavioural HD44780 byte-driver model.
// Honours LCD_FRAME_DIRTY_EN in both the expected-frame model and the dirty-line scenario.
module tb_lcd_frame_sequencer;

   localparam int GAP = 600;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       refresh;
   logic       frame_busy;
   logic       done;
   logic       lcd_start;
   logic       lcd_rs;
   logic [7:0] lcd_data;
   logic       lcd_busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [8:0] exp_q [$];
   int         exp_total = 0;
   logic [7:0] mem_m [32];
   logic [1:0] model_dirty;

   logic hold_init = 1'b1;
   logic no_ack    = 1'b0;
   logic sb_on     = 1'b0;

   int         start_count = 0;
   int         done_count  = 0;
   logic [8:0] last_byte   = '0;
   int         last_cyc    = 0;
   int         fall_cyc    = 0;
   int         fall_count  = 0;
   int         fall_used   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lcd_frame_sequencer #(.CLK_HZ(12_000_000)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .refresh    (refresh),
      .frame_busy (frame_busy),
      .done       (done),
      .lcd_start  (lcd_start),
      .lcd_rs     (lcd_rs),
      .lcd_data   (lcd_data),
      .lcd_busy   (lcd_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem_m[i] = 8'h20;
      model_dirty = 2'b11;
   endtask

   task automatic push_frame();
      logic [1:0] m;
`ifdef LCD_FRAME_DIRTY_EN
      m = model_dirty;
`else
      m = 2'b11 | model_dirty;
`endif
      model_dirty = 2'b00;
      for (int l = 0; l < 2; l++) begin
         if (m[l]) begin
            exp_q.push_back((l == 0) ? 9'h080 : 9'h0C0);
            for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, mem_m[l*16 + c]});
            exp_total += 17;
         end
      end
   endtask

   task automatic write_char(input logic ln, input logic [3:0] cl, input logic [7:0] ch);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = {ln, cl};
      wr_data = ch;
      mem_m[{ln, cl}] = ch;
      model_dirty[ln] = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_refresh();
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   // Driver model: busy held through init, otherwise rises 1 cycle after start for 10 cycles.
   initial begin
      lcd_busy = 1'b1;
      forever begin
         @(negedge clk);
         if (hold_init) begin
            lcd_busy = 1'b1;
         end else if (lcd_start && !no_ack) begin
            lcd_busy = 1'b0;
            @(negedge clk);
            lcd_busy = 1'b1;
            repeat (10) @(negedge clk);
            lcd_busy   = 1'b0;
            fall_cyc   = cyc;
            fall_count = fall_count + 1;
         end else begin
            lcd_busy = 1'b0;
         end
      end
   end

   // Output monitor and scoreboard.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (lcd_start) begin
            start_count++;
            last_byte = {lcd_rs, lcd_data};
            last_cyc  = cyc;
            if (sb_on) begin
               if (exp_q.size() == 0) begin
                  check("sb_unexpected_start", 0, 1);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, e});
               end
            end
            if (fall_count != fall_used) begin
               check("gap_ge_600", 32'((cyc - fall_cyc) >= GAP), 1);
               fall_used = fall_count;
            end
         end
         if (done) begin
            done_count++;
            check("busy_low_at_done", frame_busy, 0);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      string msg;
      int    n0, s0, d0, c1;
      logic [8:0] b1;
      msg = "CO2 412ppm";
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; refresh = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_frame_busy", frame_busy, 0);
      check("rst_done", done, 0);
      check("rst_lcd_start", lcd_start, 0);
      check("rst_lcd_rs", lcd_rs, 0);
      check("rst_lcd_data", lcd_data, 0);

      // Frame 1 requested while the driver is still initialising.
      for (int i = 0; i < 10; i++) write_char(1'b0, 4'(i), msg[i]);
      sb_on = 1'b1;
      pulse_refresh();
      push_frame();
      repeat (1000) @(negedge clk);
      check("init_no_start", start_count, 0);
      check("init_frame_busy", frame_busy, 1);
      hold_init = 1'b0;

      for (int i = 0; i < 5000 && start_count < 4; i++) @(negedge clk);
      check("wait_first_bytes", 32'(start_count >= 4), 1);
      write_char(1'b0, 4'd0, "X");
      repeat (3) begin
         pulse_refresh();
         repeat (20) @(negedge clk);
      end
      check("pending_frame_busy", frame_busy, 1);

      for (int i = 0; i < 30000 && done_count < 1; i++) @(negedge clk);
      check("frame1_done", done_count, 1);
      push_frame();
      for (int i = 0; i < 30000 && done_count < 2; i++) @(negedge clk);
      check("frame2_done", done_count, 2);
      repeat (700) @(negedge clk);
      check("two_frames_done", done_count, 2);
      check("two_frames_bytes", start_count, exp_total);
      check("sb_drained", exp_q.size(), 0);
      check("idle_frame_busy", frame_busy, 0);

`ifdef LCD_FRAME_DIRTY_EN
      write_char(1'b1, 4'd3, "Z");
      pulse_refresh();
      push_frame();
      for (int i = 0; i < 30000 && done_count < 3; i++) @(negedge clk);
      check("dirty_frame_done", done_count, 3);
      repeat (20) @(negedge clk);
      check("dirty_frame_bytes", start_count, exp_total);
      check("dirty_sb_drained", exp_q.size(), 0);
      s0 = start_count;
      @(negedge clk);
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
      check("clean_done_next_cycle", done, 1);
      repeat (100) @(negedge clk);
      check("clean_no_start", start_count, s0);
      check("clean_frame_busy", frame_busy, 0);
`endif

      // Driver never acknowledges: same byte must be re-issued, then reset aborts.
      write_char(1'b0, 4'd1, "Q");
      sb_on  = 1'b0;
      no_ack = 1'b1;
      n0 = start_count;
      pulse_refresh();
      for (int i = 0; i < 2000 && start_count < n0 + 1; i++) @(negedge clk);
      check("noack_first_start", start_count, n0 + 1);
      b1 = last_byte;
      c1 = last_cyc;
      check("noack_first_byte", {23'd0, b1}, 32'h080);
      for (int i = 0; i < 200 && start_count < n0 + 2; i++) @(negedge clk);
      check("noack_resend", start_count, n0 + 2);
      check("noack_resend_byte", {23'd0, last_byte}, {23'd0, b1});
      check("noack_interval", 32'((last_cyc - c1) >= 16 && (last_cyc - c1) <= 18), 1);

      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      s0 = start_count;
      d0 = done_count;
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("rst_abort_no_start", start_count, s0);
      check("rst_abort_no_done", done_count, d0);
      check("rst_abort_idle", frame_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
